// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the command-script sequencer.
// Optional handshake timeout in cmd_script_seq is enabled by CMD_SEQ_TIMEOUT_EN.
package cmd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_SENT,
    WAIT_RESP,
    CAPTURE,
    CHECK,
    GAP,
    DONE
  } state_t;

  // Copter command bytes understood by CommMaster
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;
  localparam logic [7:0] POS_ACK   = 8'hA5;

  // Fixed-width part of a script entry: cmd(8) + resp(8) + chk(1)
  localparam int ENTRY_FIXED_W = 17;

  function automatic logic resp_ok(input logic chk, input logic [7:0] exp_resp,
                                   input logic [7:0] got);
    return !chk || (got == exp_resp);
  endfunction

endpackage

// File: rtl/cmd_seq_ram.sv
// Script storage: one write port, one read port with a registered read.
module cmd_seq_ram
  import cmd_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8 + ENTRY_FIXED_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cmd_script_seq.sv
// Replays a loaded {cmd, data, expected resp} script into CommMaster and tallies results.
// Define CMD_SEQ_TIMEOUT_EN to add a per-entry handshake timeout.
module cmd_script_seq
  import cmd_seq_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 16,
  parameter int GAP_CYC     = 1000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic                     ld_clr,
  input  logic [7:0]               ld_cmd,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic [7:0]               ld_resp,
  input  logic                     ld_chk,
  output logic                     ld_full,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               cmd,
  output logic [DATA_W-1:0]        data,
  output logic                     send_cmd,
  input  logic                     cmd_sent,
  input  logic                     resp_rdy,
  input  logic [7:0]               resp,
  output logic                     clr_resp_rdy,
  output logic [$clog2(DEPTH):0]   pass_cnt,
  output logic [$clog2(DEPTH):0]   fail_cnt,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef struct packed {
    logic [7:0]        cmd;
    logic [DATA_W-1:0] data;
    logic [7:0]        resp;
    logic              chk;
  } entry_t;

  localparam int EW = $bits(entry_t);

  entry_t            wr_entry, rd_entry;
  logic [EW-1:0]     rd_word;
  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic              last_entry;
  logic              timed_out, entry_timed_out;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     pass_q, pass_d, fail_q, fail_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fidx_q, fidx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [7:0]        cmd_q, cmd_d, resp_lat_q, resp_lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              send_cmd_q, send_cmd_d, clr_q, clr_d, done_q, done_d, busy_q, busy_d;

  assign ld_full    = (count_q == CW'(DEPTH));
  assign wr_en      = ld_en && !ld_clr && (state_q == IDLE) && !ld_full;
  assign wr_entry   = '{cmd: ld_cmd, data: ld_data, resp: ld_resp, chk: ld_chk};
  assign rd_entry   = entry_t'(rd_word);
  assign last_entry = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

  cmd_seq_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    gap_d      = gap_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    resp_lat_d = resp_lat_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fidx_d     = fidx_q;
    send_cmd_d = 1'b0;
    clr_d      = 1'b0;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (ld_clr) begin
        count_d  = '0;
        wr_ptr_d = '0;
      end else if (wr_en) begin
        count_d  = count_q + CW'(1);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pass_d   = '0;
          fail_d   = '0;
          fidx_d   = '0;
          rd_ptr_d = '0;
          if (count_q == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        cmd_d      = rd_entry.cmd;
        data_d     = rd_entry.data;
        send_cmd_d = 1'b1;
        state_d    = WAIT_SENT;
      end
      WAIT_SENT: begin
        if (timed_out)     state_d = CAPTURE;
        else if (cmd_sent) state_d = resp_rdy ? CAPTURE : WAIT_RESP;
      end
      WAIT_RESP: begin
        if (timed_out || resp_rdy) state_d = CAPTURE;
      end
      CAPTURE: begin
        resp_lat_d = resp;
        clr_d      = 1'b1;
        state_d    = CHECK;
      end
      CHECK: begin
        if (!entry_timed_out && resp_ok(rd_entry.chk, rd_entry.resp, resp_lat_q)) begin
          pass_d = pass_q + CW'(1);
        end else begin
          fail_d = fail_q + CW'(1);
          if (fail_q == '0) fidx_d = rd_ptr_q;
        end
        if (last_entry) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          gap_d    = GW'(GAP_CYC - 1);
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = ISSUE;
        else             gap_d   = gap_q - GW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d != IDLE);
    // Reading at the next pointer keeps the entry valid in ISSUE and CHECK.
    rd_addr = rd_ptr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      gap_q      <= '0;
      cmd_q      <= '0;
      data_q     <= '0;
      resp_lat_q <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      fidx_q     <= '0;
      send_cmd_q <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      gap_q      <= gap_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      resp_lat_q <= resp_lat_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fidx_q     <= fidx_d;
      send_cmd_q <= send_cmd_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

`ifdef CMD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          to_hit_q, to_hit_d, to_err_q, to_err_d;

  assign timed_out = ((state_q == WAIT_SENT) || (state_q == WAIT_RESP)) &&
                     (timer_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    timer_d  = timer_q;
    to_hit_d = to_hit_q;
    to_err_d = to_err_q;
    if ((state_q == IDLE) && start) to_err_d = 1'b0;
    if (state_q == ISSUE) begin
      timer_d  = '0;
      to_hit_d = 1'b0;
    end else if (timed_out) begin
      to_hit_d = 1'b1;
      to_err_d = 1'b1;
    end else if ((state_q == WAIT_SENT) || (state_q == WAIT_RESP)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q  <= '0;
      to_hit_q <= 1'b0;
      to_err_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      to_hit_q <= to_hit_d;
      to_err_q <= to_err_d;
    end
  end

  assign entry_timed_out = to_hit_q;
  assign timeout_err     = to_err_q;
`else
  assign timed_out       = 1'b0;
  assign entry_timed_out = 1'b0;
  assign timeout_err     = 1'b0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign cmd          = cmd_q;
  assign data         = data_q;
  assign send_cmd     = send_cmd_q;
  assign clr_resp_rdy = clr_q;
  assign pass_cnt     = pass_q;
  assign fail_cnt     = fail_q;
  assign fail_idx     = fidx_q;

endmodule

// File: tb/tb_cmd_script_seq.sv
// Randomized self-checking bench for cmd_script_seq with a queue-based script model
// and a CommMaster responder; the timeout scenario runs when CMD_SEQ_TIMEOUT_EN is defined.
module tb_cmd_script_seq;
  import cmd_seq_pkg::*;

  localparam int DATA_W      = 16;
  localparam int DEPTH       = 16;
  localparam int GAP_CYC     = 20;
  localparam int TIMEOUT_CYC = 100;
  localparam int AW          = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ld_en = 0, ld_clr = 0, ld_chk = 0, start = 0;
  logic [7:0]        ld_cmd = 0, ld_resp = 0, resp = 0;
  logic [DATA_W-1:0] ld_data = 0;
  logic              cmd_sent = 0, resp_rdy = 0;
  logic              ld_full, busy, done, send_cmd, clr_resp_rdy, timeout_err;
  logic [7:0]        cmd;
  logic [DATA_W-1:0] data;
  logic [AW:0]       pass_cnt, fail_cnt;
  logic [AW-1:0]     fail_idx;

  cmd_script_seq #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_clr(ld_clr), .ld_cmd(ld_cmd),
    .ld_data(ld_data), .ld_resp(ld_resp), .ld_chk(ld_chk), .ld_full(ld_full),
    .start(start), .busy(busy), .done(done), .cmd(cmd), .data(data),
    .send_cmd(send_cmd), .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp),
    .clr_resp_rdy(clr_resp_rdy), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_idx(fail_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [15:0] d;
    logic [7:0]  r;
    bit          k;
  } ent_t;

  ent_t       scr[$];
  logic [7:0] answer[DEPTH];
  bit         silent[DEPTH];

  logic [7:0] cmd_pool[7] = '{SET_PTCH, SET_ROLL, SET_YAW, SET_THRST, CALIBRATE, EMER_LAND, MTRS_OFF};

  task automatic load_entry(input logic [7:0] c, input logic [15:0] d,
                            input logic [7:0] r, input bit k);
    ent_t e;
    ld_cmd = c; ld_data = d; ld_resp = r; ld_chk = k; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    if (scr.size() < DEPTH) begin
      e = '{c: c, d: d, r: r, k: k};
      scr.push_back(e);
    end
  endtask

  task automatic clear_script();
    ld_clr = 1'b1;
    @(negedge clk);
    ld_clr = 1'b0;
    scr.delete();
  endtask

  task automatic empty_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_nosend"}, send_cmd, 0);
    check_eq({tag, "_pass"}, pass_cnt, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 0);
  endtask

  // Starts the script, plays CommMaster, checks every issue and the final tallies.
  // abort_at>0 returns while entry abort_at-1 sits waiting for its response.
  task automatic run_script(input string tag, input int abort_at);
    int  n, exp_pass, exp_fail, exp_fidx, cyc, issued, cur;
    int  sent_cd, resp_cd, last_resp, abort_cnt, silent_iss, any_silent;
    bit  resp_pend, got_done, aborting, to_seen, ok;
    n = scr.size();
    exp_pass = 0; exp_fail = 0; exp_fidx = 0; any_silent = 0;
    for (int i = 0; i < n; i++) begin
      ok = !silent[i] && (!scr[i].k || answer[i] == scr[i].r);
      if (silent[i]) any_silent = 1;
      if (ok) exp_pass++;
      else begin
        if (exp_fail == 0) exp_fidx = i;
        exp_fail++;
      end
    end
    cyc = 0; issued = 0; cur = 0; sent_cd = 0; resp_cd = 0; last_resp = -1;
    abort_cnt = 0; silent_iss = 0;
    resp_pend = 0; got_done = 0; aborting = 0; to_seen = 0;
    start = 1'b1;
    while (cyc < 20000 && !got_done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      cmd_sent = 1'b0;
      if (clr_resp_rdy) resp_rdy = 1'b0;
      if (timeout_err && !to_seen) begin
        to_seen = 1;
        check_eq({tag, "_to_lat"}, cyc - silent_iss, TIMEOUT_CYC);
      end
      if (send_cmd) begin
        if (issued == 0) check_eq({tag, "_latency"}, cyc, 2);
        if (issued < n) begin
          check_eq({tag, "_cmd"}, cmd, scr[issued].c);
          check_eq({tag, "_data"}, data, scr[issued].d);
        end
        if (last_resp >= 0) check_eq({tag, "_gap"}, (cyc - last_resp) >= GAP_CYC, 1);
        cur = issued;
        issued++;
        resp_pend = 0;
        if (cur < DEPTH && silent[cur]) begin
          sent_cd = 0;
          silent_iss = cyc;
        end else begin
          sent_cd = $urandom_range(1, 4);
        end
      end else if (sent_cd > 0) begin
        sent_cd--;
        if (sent_cd == 0) begin
          cmd_sent = 1'b1;
          resp_cd = $urandom_range(0, 3);
          if (abort_at == issued) begin
            aborting = 1; abort_cnt = 3;
          end else if (resp_cd == 0) begin
            resp_rdy = 1'b1; resp = answer[cur % DEPTH]; last_resp = cyc;
          end else begin
            resp_pend = 1;
          end
        end
      end else if (resp_pend) begin
        resp_cd--;
        if (resp_cd == 0) begin
          resp_pend = 0; resp_rdy = 1'b1; resp = answer[cur % DEPTH]; last_resp = cyc;
        end
      end
      if (aborting) begin
        abort_cnt--;
        if (abort_cnt == 0) begin
          $display("run %s: aborted after %0d issues, pass=%0d", tag, issued, pass_cnt);
          return;
        end
      end
      if (done) begin
        got_done = 1;
        $display("run %s: issued=%0d pass=%0d fail=%0d fail_idx=%0d", tag, issued,
                 pass_cnt, fail_cnt, fail_idx);
        check_eq({tag, "_issued"}, issued, n);
        check_eq({tag, "_pass_cnt"}, pass_cnt, exp_pass);
        check_eq({tag, "_fail_cnt"}, fail_cnt, exp_fail);
        if (exp_fail > 0) check_eq({tag, "_fail_idx"}, fail_idx, exp_fidx);
        check_eq({tag, "_timeout_err"}, timeout_err, any_silent);
      end
    end
    if (!got_done) check_eq({tag, "_no_done"}, 0, 1);
    @(negedge clk);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic set_answers_from_script(input int mismatch_idx);
    for (int i = 0; i < DEPTH; i++) begin
      silent[i] = 0;
      answer[i] = (i < scr.size()) ? scr[i].r : POS_ACK;
      if (i == mismatch_idx) answer[i] = 8'h5A;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin silent[i] = 0; answer[i] = POS_ACK; end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_send", send_cmd, 0);
    check_eq("rst_full", ld_full, 0);
    check_eq("rst_pass", pass_cnt, 0);
    check_eq("rst_fail", fail_cnt, 0);
    check_eq("rst_to", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    empty_start("empty0");

    // Full pass run
    load_entry(MTRS_OFF, 16'h0420, POS_ACK, 1);
    load_entry(CALIBRATE, 16'hF0F0, POS_ACK, 1);
    load_entry(SET_PTCH, 16'h0020, POS_ACK, 1);
    set_answers_from_script(-1);
    run_script("pass3", 0);

    // Single mismatch on entry 2
    clear_script();
    for (int i = 0; i < 4; i++) load_entry(cmd_pool[i], 16'($urandom), POS_ACK, 1);
    set_answers_from_script(2);
    run_script("mism", 0);

    // Don't-care entries answered with FF
    clear_script();
    load_entry(SET_YAW, 16'h1234, POS_ACK, 0);
    load_entry(SET_ROLL, 16'h8001, POS_ACK, 1);
    load_entry(EMER_LAND, 16'hFFFF, 8'h33, 0);
    set_answers_from_script(-1);
    answer[0] = 8'hFF; answer[2] = 8'hFF;
    run_script("dcare", 0);

    // Full script plus one dropped extra entry
    clear_script();
    for (int i = 0; i <= DEPTH; i++) begin
      load_entry(cmd_pool[$urandom_range(0, 6)], 16'($urandom), POS_ACK, 1);
      if (i == DEPTH - 2) check_eq("not_full", ld_full, 0);
      if (i >= DEPTH - 1) check_eq("full", ld_full, 1);
    end
    set_answers_from_script(-1);
    for (int i = 0; i < DEPTH; i++) if ($urandom_range(0, 3) == 0) answer[i] = 8'($urandom);
    run_script("full", 0);
    run_script("replay", 0);
    clear_script();
    check_eq("clr_full", ld_full, 0);
    empty_start("clr");

    // Random scripts
    for (int t = 0; t < 4; t++) begin
      int len;
      clear_script();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        load_entry(cmd_pool[$urandom_range(0, 6)], 16'($urandom),
                   ($urandom_range(0, 1) == 1) ? POS_ACK : 8'($urandom),
                   $urandom_range(0, 3) != 0);
      set_answers_from_script(-1);
      for (int i = 0; i < len; i++) if ($urandom_range(0, 9) < 3) answer[i] = 8'($urandom);
      run_script($sformatf("rand%0d", t), 0);
    end

    // Reset while entry 1 waits for its response
    clear_script();
    for (int i = 0; i < 3; i++) load_entry(cmd_pool[i + 2], 16'(i * 16'h1111), POS_ACK, 1);
    set_answers_from_script(-1);
    run_script("midrst", 2);
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_pass", pass_cnt, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_cmd", cmd, 0);
    check_eq("arst_data", data, 0);
    check_eq("arst_pass", pass_cnt, 0);
    check_eq("arst_send", send_cmd, 0);
    check_eq("arst_clr", clr_resp_rdy, 0);
    resp_rdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    scr.delete();
    @(negedge clk);
    empty_start("post_rst");
    for (int i = 0; i < 3; i++) load_entry(cmd_pool[i], 16'($urandom), POS_ACK, 1);
    set_answers_from_script(-1);
    run_script("after_rst", 0);

`ifdef CMD_SEQ_TIMEOUT_EN
    clear_script();
    for (int i = 0; i < 3; i++) load_entry(cmd_pool[i + 3], 16'($urandom), POS_ACK, 1);
    set_answers_from_script(-1);
    silent[0] = 1;
    run_script("timeout", 0);
    silent[0] = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
